mix_columns_engine: RTL and testbench
=====================================

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, meaning columns transformed per CALC cycle; legal values are 1, 2 and 4.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit, meaning the upstream block is offering a state.
REQ-005 SHALL have port in_ready, output, 1 bit, meaning the engine accepts a state this cycle.
REQ-006 SHALL have port in_state, input, 128 bits, the AES state: byte k = bits [127-8k -: 8]; column c = bytes 4c..4c+3; row r of column c = byte 4c+r.
REQ-007 SHALL have port in_inv, input, 1 bit, mode select: 0 = MixColumns, 1 = InvMixColumns; sampled at acceptance.
REQ-008 SHALL have port out_valid, output, 1 bit, meaning out_state holds a finished result.
REQ-009 SHALL have port out_ready, input, 1 bit, meaning downstream consumes the result.
REQ-010 SHALL have port out_state, output, 128 bits, the transformed state, same byte map as in_state.
REQ-011 SHALL have port busy, output, 1 bit, high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, CALC, DONE.
REQ-013 SHALL assert in_ready only in IDLE; a transfer occurs on in_valid && in_ready.
REQ-014 SHALL, on a transfer, latch in_state and in_inv, clear the column counter, and go IDLE->CALC.
REQ-015 SHALL, in CALC, each cycle transform columns counter..counter+COLS_PER_CYCLE-1 in place and advance the counter by COLS_PER_CYCLE.
REQ-016 SHALL go CALC->DONE in the cycle the last column group is written; the counter wraps to 0.
REQ-017 SHALL assert out_valid exactly 4/COLS_PER_CYCLE cycles after the transfer cycle (4, 2 or 1).
REQ-018 SHALL hold out_valid and out_state stable in DONE until out_ready is high; DONE->IDLE on out_valid && out_ready.
REQ-019 SHALL NOT accept a new state in the cycle the result is consumed; in_ready rises the following cycle.
REQ-020 SHALL ignore in_valid and in_inv while busy; stalls on out_ready are unbounded with no data loss.
REQ-021 SHALL compute forward column output row r as 02*a[r] ^ 03*a[r+1] ^ a[r+2] ^ a[r+3], indices mod 4.
REQ-022 SHALL compute inverse row r as 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3], indices mod 4.
REQ-023 SHALL perform all products in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B), built from xtime: shift left 1, XOR 0x1B when the shifted-out bit is 1; all results are exactly 8 bits.
REQ-024 SHALL fail elaboration for any COLS_PER_CYCLE outside {1, 2, 4}.
REQ-025 SHALL drive out_state to the internal state register at all times; the value is defined only while out_valid is high.

Reset
REQ-026 SHALL, while rst_n is low, immediately force FSM = IDLE, counter = 0, state register = 0, latched mode = 0, out_valid = 0, busy = 0, in_ready = 0, out_state = 128'h0.
REQ-027 SHALL drive in_ready = 1 from the first clock edge after rst_n deasserts.
REQ-028 SHALL discard an in-flight operation on reset assertion in CALC or DONE; no partial result is ever presented.

Configuration
REQ-029 SHALL, with macro MIX_COLUMNS_INV_MIX_EN defined, compile the inverse datapath; in_inv = 1 selects REQ-022.
REQ-030 SHALL, without MIX_COLUMNS_INV_MIX_EN, omit the inverse datapath, keep the in_inv port, ignore its value, and always apply REQ-021.

Verification
REQ-031 SHALL check forward, COLS_PER_CYCLE=1: in_state 128'hdb135345_f20a225c_01010101_c6c6c6c6, in_inv=0 -> out_state 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid 4 cycles after transfer.
REQ-032 SHALL check forward, COLS_PER_CYCLE=4: 128'hd4d4d4d5_2d26314c_db135345_01010101 -> 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_01010101, out_valid 1 cycle after transfer.
REQ-033 SHALL check inverse with MIX_COLUMNS_INV_MIX_EN, COLS_PER_CYCLE=2: 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, in_inv=1 -> 128'hdb135345_f20a225c_01010101_c6c6c6c6, out_valid after 2 cycles; without the macro the same stimulus -> forward result.
REQ-034 SHALL check backpressure: out_ready low for 10 cycles in DONE -> out_valid and out_state stable, in_ready 0, in_valid pulses ignored; out_ready high -> one transfer, in_ready 1 next cycle.
REQ-035 SHALL check reset mid-CALC: rst_n low in cycle 2 of a COLS_PER_CYCLE=1 run -> all outputs at reset values same cycle, no out_valid afterwards, next operation correct.

Source files
------------

// File: rtl/mix_columns_engine.sv
// AES (Inv)MixColumns engine: accepts a 128-bit state, transforms COLS_PER_CYCLE
// columns per cycle in place. Define MIX_COLUMNS_INV_MIX_EN to build the inverse datapath.

module mix_columns_lane (
  input  logic [31:0] col_i,
`ifdef MIX_COLUMNS_INV_MIX_EN
  input  logic        inv_i,
`endif
  output logic [31:0] col_o
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [7:0] a0, a1, a2, a3, fwd;
    assign a0  = col_i[31-8*r -: 8];
    assign a1  = col_i[31-8*((r+1)%4) -: 8];
    assign a2  = col_i[31-8*((r+2)%4) -: 8];
    assign a3  = col_i[31-8*((r+3)%4) -: 8];
    assign fwd = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
`ifdef MIX_COLUMNS_INV_MIX_EN
    logic [7:0] inv;
    // 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3, each coefficient split into powers of x
    assign inv = (xt(xt(xt(a0))) ^ xt(xt(a0)) ^ xt(a0))
               ^ (xt(xt(xt(a1))) ^ xt(a1) ^ a1)
               ^ (xt(xt(xt(a2))) ^ xt(xt(a2)) ^ a2)
               ^ (xt(xt(xt(a3))) ^ a3);
    assign col_o[31-8*r -: 8] = inv_i ? inv : fwd;
`else
    assign col_o[31-8*r -: 8] = fwd;
`endif
  end

endmodule

module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int CPC = COLS_PER_CYCLE;

  if (CPC != 1 && CPC != 2 && CPC != 4) begin : g_bad_cpc
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(CPC);
  localparam logic [1:0] LAST = 2'(4 - CPC);

  typedef enum logic [1:0] {IDLE, CALC, DONE} fsm_e;

  fsm_e             fsm_q;
  logic [1:0]       cnt_q;
  logic [3:0][31:0] st_q, st_d;
  logic             out_valid_q, in_ready_q;
`ifdef MIX_COLUMNS_INV_MIX_EN
  logic             inv_q;
`else
  logic             unused_in_inv;
  assign unused_in_inv = in_inv;
`endif

  logic [CPC-1:0][31:0] lane_in, lane_out;
  logic [1:0]           pos [CPC];

  // Column c lives at packed index 3-c so byte 0 sits at the MSBs.
  for (genvar g = 0; g < CPC; g++) begin : g_lane
    assign pos[g]     = 2'd3 - (cnt_q + 2'(g));
    assign lane_in[g] = st_q[pos[g]];
    mix_columns_lane u_lane (
      .col_i (lane_in[g]),
`ifdef MIX_COLUMNS_INV_MIX_EN
      .inv_i (inv_q),
`endif
      .col_o (lane_out[g])
    );
  end

  always_comb begin
    st_d = st_q;
    for (int g = 0; g < CPC; g++) st_d[pos[g]] = lane_out[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      cnt_q       <= 2'd0;
      st_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef MIX_COLUMNS_INV_MIX_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      case (fsm_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            st_q       <= in_state;
            cnt_q      <= 2'd0;
            fsm_q      <= CALC;
            in_ready_q <= 1'b0;
`ifdef MIX_COLUMNS_INV_MIX_EN
            inv_q      <= in_inv;
`endif
          end
        end
        CALC: begin
          st_q  <= st_d;
          cnt_q <= cnt_q + STEP;
          if (cnt_q == LAST) begin
            fsm_q       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          fsm_q       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = st_q;
  assign busy      = (fsm_q != IDLE);

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: one instance per legal COLS_PER_CYCLE, directed
// vectors plus random states checked against a GF(2^8) matrix-product model.

module tb_mix_columns_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ival [3], iinv [3], ordy [3], ird [3], ovld [3], bsy [3];
  logic [127:0] ist [3], ost [3];
  int           checks = 0;
  int           errs = 0;

`ifdef MIX_COLUMNS_INV_MIX_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mix_columns_engine #(.COLS_PER_CYCLE(1 << k)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (ival[k]),
      .in_ready  (ird[k]),
      .in_state  (ist[k]),
      .in_inv    (iinv[k]),
      .out_valid (ovld[k]),
      .out_ready (ordy[k]),
      .out_state (ost[k]),
      .busy      (bsy[k])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit inv);
    logic [7:0]   cf [4];
    logic [7:0]   b [16];
    logic [7:0]   acc;
    logic [127:0] r = '0;
    if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gmul(cf[j], b[4*c + (rr+j)%4]);
        r[127-8*(4*c+rr) -: 8] = acc;
      end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_in_ready"},  ird[k],  1'b0);
      chk({tag, "_out_valid"}, ovld[k], 1'b0);
      chk({tag, "_busy"},      bsy[k],  1'b0);
      chk({tag, "_out_state"}, ost[k],  128'h0);
    end
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    while (ird[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_in_ready", ird[k], 1'b1);
  endtask

  task automatic run_op(input int k, input logic [127:0] st, input logic inv,
                        input logic [127:0] expd, input int stall);
    logic [127:0] held;
    int           lat;
    wait_ready(k);
    ival[k] = 1'b1; ist[k] = st; iinv[k] = inv; ordy[k] = 1'b0;
    @(negedge clk);
    ival[k] = 1'b0;
    chk("busy_after_accept", bsy[k], 1'b1);
    chk("ready_after_accept", ird[k], 1'b0);
    lat = 0;
    while (ovld[k] !== 1'b1 && lat < 20) begin
      ival[k] = 1'($urandom); iinv[k] = 1'($urandom);
      ist[k]  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      lat++;
    end
    ival[k] = 1'b0;
    chk("latency", 128'(lat), 128'(4 >> k));
    chk("out_state", ost[k], expd);
    held = ost[k];
    for (int s = 0; s < stall; s++) begin
      ival[k] = 1'($urandom); iinv[k] = 1'($urandom);
      ist[k]  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("stall_valid", ovld[k], 1'b1);
      chk("stall_state", ost[k], held);
      chk("stall_in_ready", ird[k], 1'b0);
    end
    ival[k] = 1'b0; ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    chk("consumed_valid", ovld[k], 1'b0);
    chk("consumed_in_ready", ird[k], 1'b1);
    chk("consumed_busy", bsy[k], 1'b0);
  endtask

  initial begin
    logic [127:0] s;
    logic         m;
    for (int k = 0; k < 3; k++) begin
      ival[k] = 1'b0; iinv[k] = 1'b0; ordy[k] = 1'b0; ist[k] = '0;
    end
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("ready_after_reset", ird[k], 1'b1);

    run_op(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
              128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 0);
    run_op(2, 128'hd4d4d4d5_2d26314c_db135345_01010101, 1'b0,
              128'hd5d5d7d6_4d7ebdf8_8e4da1bc_01010101, 2);
    s = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    run_op(1, s, 1'b1,
           INV_EN ? 128'hdb135345_f20a225c_01010101_c6c6c6c6 : mix_ref(s, 1'b0), 10);
    run_op(0, 128'h0, 1'b0, 128'h0, 10);

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 6; i++) begin
        s = {$urandom, $urandom, $urandom, $urandom};
        m = 1'($urandom);
        run_op(k, s, m, mix_ref(s, m && INV_EN), int'($urandom_range(0, 3)));
      end

    // reset asserted during the second CALC cycle
    wait_ready(0);
    ival[0] = 1'b1; ist[0] = {$urandom, $urandom, $urandom, $urandom}; iinv[0] = 1'b0;
    @(negedge clk);
    ival[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_calc_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_valid_after_reset", ovld[0], 1'b0);
    end
    s = {$urandom, $urandom, $urandom, $urandom};
    run_op(0, s, 1'b0, mix_ref(s, 1'b0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
